// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, state encoding and control encodings for the multi-cycle main control
package mips_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU control unit operation select
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ORIEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    // Full set of datapath controls produced by the state decoder
    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       fault;
    } ctrl_t;

    // States that hold on a memory handshake and are subject to the timeout
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// rtl/mc_main_control_if.sv - control-to-datapath bundle for the multi-cycle main control
//
// master: the controller (drives enables/muxes, receives opcode/zero/mem_ready)
// slave : the datapath (drives opcode/zero/mem_ready, receives enables/muxes)
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       fault;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, zero_ext, pc_src, alu_op,
               instr_done, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, zero_ext, pc_src, alu_op,
               instr_done, fault
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state-to-control decode for the main control FSM
//
// Ports:
//   state     in   current FSM state
//   zero      in   ALU zero flag (qualifies the branch PC load)
//   mem_ready in   memory handshake (qualifies fetch loads and store completion)
//   ctrl      out  all datapath controls for this cycle
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle; it only lands when the read completes
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed while the register file is read
                ctrl.alu_src_b = SRCB_BRANCH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.pc_en      = zero;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ORIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.zero_ext  = 1'b1;
                ctrl.alu_op    = ALUOP_OR;
            end
            S_IMMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_HALT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS main control FSM with memory-wait timeout
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  master modport of mc_main_control_if:
//        in  opcode, zero, mem_ready
//        out pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
//            mem_to_reg, alu_src_a, alu_src_b, zero_ext, pc_src, alu_op,
//            instr_done, fault
// MEM_TIMEOUT: consecutive not-ready cycles tolerated in a wait state before
//              halting with a fault; 0 waits forever.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    mc_main_control_if.master  bus
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    ctrl_t            ctrl;

    // The counter never exceeds MEM_TIMEOUT-1, so cnt_inc cannot wrap when enabled
    assign cnt_inc     = wait_cnt + CNT_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (32'(cnt_inc) >= MEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (is_wait_state(state) && !bus.mem_ready && (state_next == state)) begin
                wait_cnt <= cnt_inc;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_REXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_ORI:       state_next = S_ORIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_REXEC:  state_next = S_RWB;
            S_ADDIEX: state_next = S_IMMWB;
            S_ORIEX:  state_next = S_IMMWB;
            S_MEMWB, S_RWB, S_BEQ, S_IMMWB, S_JUMP: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // Side-effecting strobes are suppressed while reset is held so a reset
    // arriving mid-instruction cannot commit a write or start a memory access
    always_comb begin
        bus.pc_en      = ctrl.pc_en      & ~rst;
        bus.ir_write   = ctrl.ir_write   & ~rst;
        bus.mem_read   = ctrl.mem_read   & ~rst;
        bus.mem_write  = ctrl.mem_write  & ~rst;
        bus.reg_write  = ctrl.reg_write  & ~rst;
        bus.instr_done = ctrl.instr_done & ~rst;
        bus.iord       = ctrl.iord;
        bus.reg_dst    = ctrl.reg_dst;
        bus.mem_to_reg = ctrl.mem_to_reg;
        bus.alu_src_a  = ctrl.alu_src_a;
        bus.alu_src_b  = ctrl.alu_src_b;
        bus.zero_ext   = ctrl.zero_ext;
        bus.pc_src     = ctrl.pc_src;
        bus.alu_op     = ctrl.alu_op;
        bus.fault      = ctrl.fault;
    end

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - self-checking bench for mc_main_control (no timeout and MEM_TIMEOUT=2)
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    mc_main_control_if if0 ();
    mc_main_control_if if1 ();

    assign if0.opcode    = opcode;
    assign if0.zero      = zero;
    assign if0.mem_ready = mem_ready;
    assign if1.opcode    = opcode;
    assign if1.zero      = zero;
    assign if1.mem_ready = mem_ready;

    mc_main_control #(.MEM_TIMEOUT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    mc_main_control #(.MEM_TIMEOUT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       fault;
    } outs_t;

    outs_t act0, act1;
    assign act0 = {if0.pc_en, if0.ir_write, if0.mem_read, if0.mem_write, if0.iord,
                   if0.reg_write, if0.reg_dst, if0.mem_to_reg, if0.alu_src_a,
                   if0.alu_src_b, if0.zero_ext, if0.pc_src, if0.alu_op,
                   if0.instr_done, if0.fault};
    assign act1 = {if1.pc_en, if1.ir_write, if1.mem_read, if1.mem_write, if1.iord,
                   if1.reg_write, if1.reg_dst, if1.mem_to_reg, if1.alu_src_a,
                   if1.alu_src_b, if1.zero_ext, if1.pc_src, if1.alu_op,
                   if1.instr_done, if1.fault};

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each instruction is a list of phases; a wait phase
    // lingers while mem_ready is low, and the list restarts after the last phase.
    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_REXEC,
        P_RWB, P_BEQ, P_ADDIEX, P_ORIEX, P_IMMWB, P_JUMP, P_HALT
    } phase_t;

    phase_t seq [2][8];
    int     len [2];
    int     pos [2];
    int     wc  [2];
    int     tmo [2];

    task automatic model_reset(input int m);
        seq[m][0] = P_FETCH;
        seq[m][1] = P_DECODE;
        len[m]    = 2;
        pos[m]    = 0;
        wc[m]     = 0;
    endtask

    task automatic model_halt(input int m);
        seq[m][0] = P_HALT;
        len[m]    = 1;
        pos[m]    = 0;
        wc[m]     = 0;
    endtask

    task automatic model_step(input int m);
        phase_t p;
        p = seq[m][pos[m]];
        if (rst) begin
            model_reset(m);
        end else if (p == P_HALT) begin
            wc[m] = 0;
        end else if ((p == P_FETCH || p == P_MEMRD || p == P_MEMWR) && !mem_ready) begin
            wc[m]++;
            if (tmo[m] > 0 && wc[m] >= tmo[m]) model_halt(m);
        end else begin
            wc[m] = 0;
            if (p == P_DECODE) begin
                case (opcode)
                    6'b100011: begin seq[m][2] = P_MEMADR; seq[m][3] = P_MEMRD; seq[m][4] = P_MEMWB; len[m] = 5; end
                    6'b101011: begin seq[m][2] = P_MEMADR; seq[m][3] = P_MEMWR; len[m] = 4; end
                    6'b000000: begin seq[m][2] = P_REXEC;  seq[m][3] = P_RWB;   len[m] = 4; end
                    6'b000100: begin seq[m][2] = P_BEQ;    len[m] = 3; end
                    6'b001000: begin seq[m][2] = P_ADDIEX; seq[m][3] = P_IMMWB; len[m] = 4; end
                    6'b001101: begin seq[m][2] = P_ORIEX;  seq[m][3] = P_IMMWB; len[m] = 4; end
                    6'b000010: begin seq[m][2] = P_JUMP;   len[m] = 3; end
                    default:   len[m] = 0;
                endcase
            end
            if (len[m] == 0) begin
                model_halt(m);
            end else begin
                pos[m]++;
                if (pos[m] >= len[m]) model_reset(m);
            end
        end
    endtask

    function automatic outs_t expect_out(input phase_t p, input logic z, input logic mr, input logic r);
        outs_t e;
        e        = '0;
        e.alu_op = 2'b11;
        case (p)
            P_FETCH:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
            P_DECODE: e.alu_src_b = 2'b11;
            P_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            P_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            P_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
            P_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; e.instr_done = mr; end
            P_REXEC:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b00; end
            P_RWB:    begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; end
            P_BEQ:    begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; e.instr_done = 1'b1; end
            P_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            P_ORIEX:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.zero_ext = 1'b1; e.alu_op = 2'b10; end
            P_IMMWB:  begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            P_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1; end
            P_HALT:   e.fault = 1'b1;
            default:  e = '0;
        endcase
        if (r) begin
            e.pc_en      = 1'b0;
            e.ir_write   = 1'b0;
            e.mem_write  = 1'b0;
            e.reg_write  = 1'b0;
            e.mem_read   = 1'b0;
            e.instr_done = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            check_val("dut0_outputs", 32'(act0), 32'(expect_out(seq[0][pos[0]], zero, mem_ready, rst)));
            check_val("dut1_outputs", 32'(act1), 32'(expect_out(seq[1][pos[1]], zero, mem_ready, rst)));
        end
    end

    outs_t tr0 [32];
    outs_t tr1 [32];
    int    ncyc;

    // Runs one instruction from FETCH on the no-timeout unit, stalling the
    // first 'stall' cycles, and records its per-cycle outputs.
    task automatic run_instr(input logic [5:0] op, input logic z, input int stall);
        bit done;
        opcode = op;
        zero   = z;
        ncyc   = 0;
        done   = 1'b0;
        while (!done && ncyc < 30) begin
            mem_ready = (ncyc >= stall);
            @(negedge clk);
            tr0[ncyc] = act0;
            tr1[ncyc] = act1;
            ncyc++;
            if (act0.instr_done) done = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] legal_ops [7];

    function automatic logic [5:0] pick_op();
        if ($urandom_range(0, 15) == 0) return 6'($urandom);
        return legal_ops[$urandom_range(0, 6)];
    endfunction

    initial begin
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
        tmo[0]    = 0;
        tmo[1]    = 2;
        model_reset(0);
        model_reset(1);
        rst       = 1'b1;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        idle(2);
        rst      = 1'b0;
        checking = 1'b1;

        // First cycle after reset: FETCH outputs, memory not yet ready
        @(negedge clk);
        check_val("reset_mem_read",  32'(act0.mem_read), 1);
        check_val("reset_alu_src_b", 32'(act0.alu_src_b), 1);
        check_val("reset_alu_op",    32'(act0.alu_op), 3);
        check_val("reset_ir_write",  32'(act0.ir_write), 0);
        check_val("reset_fault",     32'(act0.fault), 0);
        @(posedge clk);
        #1;

        run_instr(6'b100011, 1'b0, 0);
        check_val("lw_cycles",         ncyc, 5);
        check_val("lw_wb_reg_write",   32'(tr0[4].reg_write), 1);
        check_val("lw_wb_mem_to_reg",  32'(tr0[4].mem_to_reg), 1);
        check_val("lw_rd_iord",        32'(tr0[3].iord), 1);

        run_instr(6'b000000, 1'b0, 0);
        check_val("r_cycles",        ncyc, 4);
        check_val("r_exec_alu_op",   32'(tr0[2].alu_op), 0);
        check_val("r_wb_reg_dst",    32'(tr0[3].reg_dst), 1);
        check_val("r_wb_reg_write",  32'(tr0[3].reg_write), 1);

        run_instr(6'b000100, 1'b1, 0);
        check_val("beq_t_cycles",  ncyc, 3);
        check_val("beq_t_pc_en",   32'(tr0[2].pc_en), 1);
        check_val("beq_t_pc_src",  32'(tr0[2].pc_src), 1);
        check_val("beq_t_alu_op",  32'(tr0[2].alu_op), 1);
        run_instr(6'b000100, 1'b0, 0);
        check_val("beq_nt_cycles", ncyc, 3);
        check_val("beq_nt_pc_en",  32'(tr0[2].pc_en), 0);

        run_instr(6'b001101, 1'b0, 0);
        check_val("ori_cycles",    ncyc, 4);
        check_val("ori_alu_op",    32'(tr0[2].alu_op), 2);
        check_val("ori_zero_ext",  32'(tr0[2].zero_ext), 1);
        run_instr(6'b001000, 1'b0, 0);
        check_val("addi_cycles",   ncyc, 4);
        check_val("addi_alu_op",   32'(tr0[2].alu_op), 3);
        check_val("addi_zero_ext", 32'(tr0[2].zero_ext), 0);

        run_instr(6'b101011, 1'b0, 0);
        check_val("sw_cycles",     ncyc, 4);
        check_val("sw_mem_write",  32'(tr0[3].mem_write), 1);
        run_instr(6'b000010, 1'b0, 0);
        check_val("j_cycles",      ncyc, 3);
        check_val("j_pc_src",      32'(tr0[2].pc_src), 2);

        // Three not-ready fetch cycles: no-timeout unit waits, MEM_TIMEOUT=2 unit halts
        run_instr(6'b100011, 1'b0, 3);
        check_val("stall_cycles",     ncyc, 8);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_ir_write", 32'(tr0[i].ir_write), 0);
            check_val("stall_pc_en",    32'(tr0[i].pc_en), 0);
        end
        check_val("stall_go_ir_write", 32'(tr0[3].ir_write), 1);
        check_val("tmo_fault_before",  32'(tr1[1].fault), 0);
        check_val("tmo_fault_after",   32'(tr1[2].fault), 1);
        check_val("tmo_fault_sticky",  32'(tr1[7].fault), 1);

        do_reset();
        mem_ready = 1'b1;
        opcode    = 6'b111111;
        idle(4);
        @(negedge clk);
        check_val("illegal_fault",        32'(act0.fault), 1);
        check_val("illegal_no_mem_read", 32'(act0.mem_read), 0);
        idle(5);
        @(negedge clk);
        check_val("illegal_fault_sticky", 32'(act0.fault), 1);
        @(posedge clk);
        #1;

        // Reset landing in MEMRD of a load
        do_reset();
        opcode = 6'b100011;
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_mem_read",  32'(act0.mem_read), 0);
        check_val("rst_mid_reg_write", 32'(act0.reg_write), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_after_mem_read",  32'(act0.mem_read), 1);
        check_val("rst_after_iord",      32'(act0.iord), 0);
        check_val("rst_after_fault",     32'(act0.fault), 0);
        check_val("rst_after_reg_write", 32'(act0.reg_write), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom_range(0, 1));
            if (seq[0][pos[0]] == P_FETCH) opcode = pick_op();
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
